// File: rtl/descriptor_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_reader_if
// Purpose  : Record stream from descriptor_reader toward the matcher/UART
//            link. One packed {octave, keypoint, descriptor} record per beat,
//            transferred when rec_valid & rec_ready.
// Signals  : rec_valid      source -> sink  record present
//            rec_ready      sink -> source  sink accepts this cycle
//            rec_octave     source -> sink  0 = octave 1, 1 = octave 2
//            rec_keypoint   source -> sink  raw keypoint word
//            rec_descriptor source -> sink  {patch1..patch4}, patch1 in MSBs
// Revision : 1.0 - initial release
// ============================================================================
interface descriptor_reader_if #(
  parameter int KP_W   = 13,
  parameter int HIST_W = 24
) ();
  logic                  rec_valid;
  logic                  rec_ready;
  logic [1:0]            rec_octave;
  logic [KP_W-1:0]       rec_keypoint;
  logic [4*HIST_W-1:0]   rec_descriptor;

  modport master (
    output rec_valid, rec_octave, rec_keypoint, rec_descriptor,
    input  rec_ready
  );

  modport slave (
    input  rec_valid, rec_octave, rec_keypoint, rec_descriptor,
    output rec_ready
  );
endinterface
`default_nettype wire

// File: rtl/descriptor_reader.sv
`default_nettype none
// ============================================================================
// Module   : descriptor_reader
// Purpose  : Walks the keypoint BRAM in write order after descriptor
//            generation, fetches the 4 sub-patch histogram words of every
//            keypoint from the descriptor BRAM and emits one record per
//            keypoint on a valid/ready stream. A zero keypoint word separates
//            octave 1 from octave 2; the second zero ends the pass.
// Ports    : clk, rst_in       clock, synchronous active-high reset
//            start             1-cycle pulse, starts a pass from IDLE only
//            key_read_addr     keypoint BRAM address   (registered)
//            keypoint_read     keypoint BRAM data, READ_LATENCY after address
//            desc_read_addr    descriptor BRAM address (registered)
//            desc_read         descriptor BRAM data, READ_LATENCY after address
//            rec               record stream (master side)
//            rec_count         records accepted in the current pass
//            busy              high outside IDLE
//            reader_done       1-cycle pulse while in FINISH
// Revision : 1.0 - initial release
// ============================================================================
module descriptor_reader #(
  parameter int DIMENSION        = 64,
  parameter int NUMBER_KEYPOINTS = 1000,
  parameter int PATCH_SIZE       = 4,
  parameter int READ_LATENCY     = 2,
  localparam int KP_W    = 2*$clog2(DIMENSION)+1,
  localparam int KEY_AW  = $clog2(NUMBER_KEYPOINTS),
  localparam int HIST_W  = ($clog2(PATCH_SIZE/2*PATCH_SIZE/2)+1)*8,
  localparam int DESC_AW = $clog2(DIMENSION*DIMENSION)
) (
  input  wire logic                clk,
  input  wire logic                rst_in,
  input  wire logic                start,
  output logic [KEY_AW-1:0]        key_read_addr,
  input  wire logic [KP_W-1:0]     keypoint_read,
  output logic [DESC_AW-1:0]       desc_read_addr,
  input  wire logic [HIST_W-1:0]   desc_read,
  descriptor_reader_if.master      rec,
  output logic [KEY_AW-1:0]        rec_count,
  output logic                     busy,
  output logic                     reader_done
);

  // Wait counter must hold READ_LATENCY; keep at least one bit.
  localparam int WAIT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY+1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY);
  localparam logic [KEY_AW-1:0] KEY_LAST  = KEY_AW'(NUMBER_KEYPOINTS-1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    KEY_WAIT  = 3'd1,
    DESC_WAIT = 3'd2,
    EMIT      = 3'd3,
    FINISH    = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [KEY_AW-1:0]     key_addr_nxt;
  logic [DESC_AW-1:0]    desc_addr_nxt;
  logic [KEY_AW-1:0]     count_nxt;
  logic                  octave, octave_nxt;
  logic [WAIT_W-1:0]     wait_cnt, wait_nxt;
  logic [1:0]            patch, patch_nxt;
  logic                  out_valid, out_valid_nxt;
  logic [1:0]            out_octave, out_octave_nxt;
  logic [KP_W-1:0]       out_keypoint, out_keypoint_nxt;
  logic [4*HIST_W-1:0]   out_descriptor, out_descriptor_nxt;

  // --------------------------------------------------------------------------
  // State and datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state          <= IDLE;
      key_read_addr  <= '0;
      desc_read_addr <= '0;
      rec_count      <= '0;
      octave         <= 1'b0;
      wait_cnt       <= '0;
      patch          <= '0;
      out_valid      <= 1'b0;
      out_octave     <= '0;
      out_keypoint   <= '0;
      out_descriptor <= '0;
    end else begin
      state          <= state_nxt;
      key_read_addr  <= key_addr_nxt;
      desc_read_addr <= desc_addr_nxt;
      rec_count      <= count_nxt;
      octave         <= octave_nxt;
      wait_cnt       <= wait_nxt;
      patch          <= patch_nxt;
      out_valid      <= out_valid_nxt;
      out_octave     <= out_octave_nxt;
      out_keypoint   <= out_keypoint_nxt;
      out_descriptor <= out_descriptor_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and datapath logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt          = state;
    key_addr_nxt       = key_read_addr;
    desc_addr_nxt      = desc_read_addr;
    count_nxt          = rec_count;
    octave_nxt         = octave;
    wait_nxt           = wait_cnt;
    patch_nxt          = patch;
    out_valid_nxt      = out_valid;
    out_octave_nxt     = out_octave;
    out_keypoint_nxt   = out_keypoint;
    out_descriptor_nxt = out_descriptor;

    case (state)
      IDLE: begin
        if (start) begin
          key_addr_nxt  = '0;
          desc_addr_nxt = '0;
          count_nxt     = '0;
          octave_nxt    = 1'b0;
          wait_nxt      = '0;
          state_nxt     = KEY_WAIT;
        end
      end

      KEY_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          wait_nxt = '0;
          if (keypoint_read == '0) begin
            // First zero word closes octave 1, second ends the pass.
            if (!octave) begin
              octave_nxt   = 1'b1;
              key_addr_nxt = key_read_addr + 1'b1;
            end else begin
              state_nxt = FINISH;
            end
          end else begin
            out_keypoint_nxt = keypoint_read;
            out_octave_nxt   = {1'b0, octave};
            patch_nxt        = '0;
            state_nxt        = DESC_WAIT;
          end
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end

      DESC_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          // The first fetched sub-patch lands in the most significant slot.
          case (patch)
            2'd0:    out_descriptor_nxt[4*HIST_W-1 -: HIST_W] = desc_read;
            2'd1:    out_descriptor_nxt[3*HIST_W-1 -: HIST_W] = desc_read;
            2'd2:    out_descriptor_nxt[2*HIST_W-1 -: HIST_W] = desc_read;
            default: out_descriptor_nxt[HIST_W-1   -: HIST_W] = desc_read;
          endcase
          desc_addr_nxt = desc_read_addr + 1'b1;
          wait_nxt      = '0;
          patch_nxt     = patch + 1'b1;
          if (patch == 2'd3) begin
            out_valid_nxt = 1'b1;
            state_nxt     = EMIT;
          end
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end

      EMIT: begin
        // Record fields are only touched outside EMIT, so they hold while
        // stalled; valid is registered and never depends on ready.
        if (rec.rec_ready) begin
          out_valid_nxt = 1'b0;
          count_nxt     = rec_count + 1'b1;
          if (key_read_addr == KEY_LAST) begin
            state_nxt = FINISH;
          end else begin
            key_addr_nxt = key_read_addr + 1'b1;
            wait_nxt     = '0;
            state_nxt    = KEY_WAIT;
          end
        end
      end

      FINISH: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy               = (state != IDLE);
  assign reader_done        = (state == FINISH);
  assign rec.rec_valid      = out_valid;
  assign rec.rec_octave     = out_octave;
  assign rec.rec_keypoint   = out_keypoint;
  assign rec.rec_descriptor = out_descriptor;

endmodule
`default_nettype wire

// File: tb/tb_descriptor_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_descriptor_reader
// Purpose  : Scoreboard bench for descriptor_reader. Directed passes push
//            expected records into a queue; monitors pop and compare on every
//            accepted record. A second instance with NUMBER_KEYPOINTS=4
//            covers the end-of-BRAM exit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_descriptor_reader;
  localparam int KP_W    = 13;
  localparam int HIST_W  = 24;
  localparam int KEY_AW  = 10;
  localparam int KEY4_AW = 2;
  localparam int DESC_AW = 12;
  localparam int RL      = 2;
  localparam int LIMIT   = 3000;

  typedef struct packed {
    logic [1:0]          oct;
    logic [KP_W-1:0]     kp;
    logic [4*HIST_W-1:0] desc;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_in, start, start4, stall_en, rdy;
  logic [KEY_AW-1:0]   key_read_addr, rec_count;
  logic [DESC_AW-1:0]  desc_read_addr;
  logic [KP_W-1:0]     keypoint_read;
  logic [HIST_W-1:0]   desc_read;
  logic                busy, reader_done;

  logic [KEY4_AW-1:0]  key_read_addr4, rec_count4;
  logic [DESC_AW-1:0]  desc_read_addr4;
  logic [KP_W-1:0]     keypoint_read4;
  logic [HIST_W-1:0]   desc_read4;
  logic                busy4, reader_done4;

  descriptor_reader_if #(.KP_W(KP_W), .HIST_W(HIST_W)) rec  ();
  descriptor_reader_if #(.KP_W(KP_W), .HIST_W(HIST_W)) rec4 ();

  descriptor_reader #(.DIMENSION(64), .NUMBER_KEYPOINTS(1000), .PATCH_SIZE(4),
                      .READ_LATENCY(RL)) dut (
    .clk(clk), .rst_in(rst_in), .start(start),
    .key_read_addr(key_read_addr), .keypoint_read(keypoint_read),
    .desc_read_addr(desc_read_addr), .desc_read(desc_read),
    .rec(rec), .rec_count(rec_count), .busy(busy), .reader_done(reader_done)
  );

  descriptor_reader #(.DIMENSION(64), .NUMBER_KEYPOINTS(4), .PATCH_SIZE(4),
                      .READ_LATENCY(RL)) dut4 (
    .clk(clk), .rst_in(rst_in), .start(start4),
    .key_read_addr(key_read_addr4), .keypoint_read(keypoint_read4),
    .desc_read_addr(desc_read_addr4), .desc_read(desc_read4),
    .rec(rec4), .rec_count(rec_count4), .busy(busy4), .reader_done(reader_done4)
  );

  assign rec.rec_ready  = rdy;
  assign rec4.rec_ready = 1'b1;

  // BRAM models: two register stages = 2 cycles address to data.
  // Descriptor word at address a holds a+1.
  logic [KP_W-1:0]   kmem  [0:15];
  logic [KP_W-1:0]   kmem4 [0:3];
  logic [KP_W-1:0]   kp_s1, kp4_s1;
  logic [HIST_W-1:0] d_s1, d4_s1;

  always @(posedge clk) begin
    kp_s1          <= (key_read_addr < 10'd16) ? kmem[key_read_addr[3:0]] : '0;
    keypoint_read  <= kp_s1;
    d_s1           <= HIST_W'(desc_read_addr) + 24'd1;
    desc_read      <= d_s1;
    kp4_s1         <= kmem4[key_read_addr4];
    keypoint_read4 <= kp4_s1;
    d4_s1          <= HIST_W'(desc_read_addr4) + 24'd1;
    desc_read4     <= d4_s1;
  end

  int   checks = 0;
  int   failures = 0;
  rec_t q[$];
  rec_t q4[$];
  int   acc, acc4, done_cnt, done_cnt4, valid_cycles, stall_cnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input int oct, input logic [KP_W-1:0] kp, input int base);
    rec_t r;
    r.oct  = 2'(oct);
    r.kp   = kp;
    r.desc = {24'(base+1), 24'(base+2), 24'(base+3), 24'(base+4)};
    return r;
  endfunction

  // Ready driver: either always ready, or hold ready low ~20 cycles per record.
  initial begin
    rdy = 1'b0;
    stall_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!stall_en) rdy = 1'b1;
      else if (rec.rec_valid && !rdy) begin
        if (stall_cnt == 20) begin rdy = 1'b1; stall_cnt = 0; end
        else stall_cnt++;
      end else rdy = 1'b0;
    end
  end

  // Main monitor
  rec_t prev;
  logic prev_stall;
  always @(negedge clk) begin
    rec_t e;
    if (rst_in) begin
      acc = 0;
      prev_stall = 1'b0;
    end else begin
      if (start && !busy) begin acc = 0; done_cnt = 0; valid_cycles = 0; end
      if (reader_done) done_cnt++;
      if (rec.rec_valid) valid_cycles++;
      if (rec.rec_valid && prev_stall) begin
        check("stall_octave",     rec.rec_octave,     prev.oct);
        check("stall_keypoint",   rec.rec_keypoint,   prev.kp);
        check("stall_descriptor", rec.rec_descriptor, prev.desc);
      end
      if (rec.rec_valid && rec.rec_ready) begin
        check("rec_count_at_handshake", rec_count, acc);
        if (q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_record actual=%0h required=none", rec.rec_keypoint);
        end else begin
          e = q.pop_front();
          check("rec_octave",     rec.rec_octave,     e.oct);
          check("rec_keypoint",   rec.rec_keypoint,   e.kp);
          check("rec_descriptor", rec.rec_descriptor, e.desc);
        end
        acc++;
      end
      prev_stall = rec.rec_valid && !rec.rec_ready;
      prev = {rec.rec_octave, rec.rec_keypoint, rec.rec_descriptor};
    end
  end

  // Monitor for the 4-entry instance
  always @(negedge clk) begin
    rec_t e;
    if (rst_in) acc4 = 0;
    else begin
      if (start4 && !busy4) begin acc4 = 0; done_cnt4 = 0; end
      if (reader_done4) done_cnt4++;
      if (rec4.rec_valid) begin
        if (q4.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_record4 actual=%0h required=none", rec4.rec_keypoint);
        end else begin
          e = q4.pop_front();
          check("rec4_octave",     rec4.rec_octave,     e.oct);
          check("rec4_keypoint",   rec4.rec_keypoint,   e.kp);
          check("rec4_descriptor", rec4.rec_descriptor, e.desc);
        end
        acc4++;
      end
    end
  end

  task automatic load_test1();
    for (int i = 0; i < 16; i++) kmem[i] = '0;
    kmem[0] = 13'h0A5B; kmem[1] = 13'h1234; kmem[2] = 13'h0000;
    kmem[3] = 13'h0F0F; kmem[4] = 13'h0000;
    q.push_back(mk(0, 13'h0A5B, 0));
    q.push_back(mk(0, 13'h1234, 4));
    q.push_back(mk(1, 13'h0F0F, 8));
  endtask

  // n = cycle index of the done pulse, cycle 1 being the first after IDLE.
  task automatic run_pass(input bit inject, output int n);
    bit injected;
    injected = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 1;
    while (!reader_done && n < LIMIT) begin
      if (inject && !injected && rec.rec_valid && !rec.rec_ready) begin
        start = 1'b1;
        injected = 1'b1;
      end
      @(posedge clk); #1;
      if (start) begin
        start = 1'b0;
        check("busy_after_stray_start", busy, 1'b1);
      end
      n++;
    end
    check("done_within_budget", reader_done, 1'b1);
    if (inject) check("stray_start_issued", injected, 1'b1);
  endtask

  task automatic end_checks(input string tag, input int cnt, input int daddr);
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_pulses"},    done_cnt, 1);
    check({tag, "_queue_left"},     q.size(), 0);
    check({tag, "_rec_count"},      rec_count, 10'(cnt));
    check({tag, "_desc_read_addr"}, desc_read_addr, 12'(daddr));
    check({tag, "_busy_idle"},      busy, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_read_addr"},  key_read_addr, 0);
    check({tag, "_desc_read_addr"}, desc_read_addr, 0);
    check({tag, "_rec_valid"},      rec.rec_valid, 0);
    check({tag, "_rec_octave"},     rec.rec_octave, 0);
    check({tag, "_rec_keypoint"},   rec.rec_keypoint, 0);
    check({tag, "_rec_descriptor"}, rec.rec_descriptor, 0);
    check({tag, "_rec_count"},      rec_count, 0);
    check({tag, "_busy"},           busy, 0);
    check({tag, "_reader_done"},    reader_done, 0);
  endtask

  initial begin
    int n;
    rst_in = 1'b1; start = 1'b0; start4 = 1'b0; stall_en = 1'b0;
    acc = 0; acc4 = 0; done_cnt = 0; done_cnt4 = 0; valid_cycles = 0;
    for (int i = 0; i < 16; i++) kmem[i] = '0;
    kmem4[0] = 13'h0111; kmem4[1] = 13'h0222; kmem4[2] = 13'h0333; kmem4[3] = 13'h1444;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    check("reset4_valid", rec4.rec_valid, 0);
    check("reset4_busy",  busy4, 0);
    rst_in = 1'b0;

    // Test 1: three records across two octaves, ready always high.
    load_test1();
    run_pass(1'b0, n);
    check("t1_done_cycle", n, 55);
    end_checks("t1", 3, 12);

    // Test 2: same data, ready stalled at each record.
    stall_en = 1'b1;
    load_test1();
    run_pass(1'b0, n);
    end_checks("t2", 3, 12);
    stall_en = 1'b0;

    // Test 3: both octaves empty.
    for (int i = 0; i < 16; i++) kmem[i] = '0;
    run_pass(1'b0, n);
    check("t3_done_cycle", n, 2*(RL+1)+1);
    check("t3_valid_cycles", valid_cycles, 0);
    end_checks("t3", 0, 0);

    // Test 5: reset during DESC_WAIT of record 2, then a clean rerun.
    load_test1();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 500 && acc < 1; i++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    check("t5_busy_before_reset", busy, 1'b1);
    rst_in = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("t5_reset");
    rst_in = 1'b0;
    q.delete();
    check("t5_no_done_on_abort", done_cnt, 0);
    load_test1();
    run_pass(1'b0, n);
    check("t5_done_cycle", n, 55);
    end_checks("t5", 3, 12);

    // Test 6: stray start while a record is stalled in EMIT.
    stall_en = 1'b1;
    load_test1();
    run_pass(1'b1, n);
    end_checks("t6", 3, 12);
    stall_en = 1'b0;

    // Test 4: four-entry BRAM, all keypoints nonzero.
    for (int i = 0; i < 4; i++) q4.push_back(mk(0, kmem4[i], 4*i));
    @(posedge clk); #1 start4 = 1'b1;
    @(posedge clk); #1 start4 = 1'b0;
    for (int i = 0; i < LIMIT && !reader_done4; i++) begin @(posedge clk); #1; end
    check("t4_done_within_budget", reader_done4, 1'b1);
    check("t4_final_key_addr", key_read_addr4, 2'd3);
    repeat (3) @(posedge clk);
    #1;
    check("t4_records", acc4, 4);
    check("t4_queue_left", q4.size(), 0);
    check("t4_done_pulses", done_cnt4, 1);
    check("t4_desc_read_addr", desc_read_addr4, 12'd16);
    check("t4_busy_idle", busy4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
